// File: rtl/scsi_wr_unpack_fifo.sv
// Longword FIFO + holding register unpacked MSB-first into one peripheral write per _DREQ for the WD33C93A.
// _DACK falls on the 3rd edge after FIFO_WR is raised into an idle empty block; pushes while full are dropped.
module scsi_wr_unpack_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int IOW_CYCLES = 2
) (
  input  logic                        i_sclk,
  input  logic                        i_rst_n,
  input  logic                        i_fifo_wr,
  input  logic [31:0]                 i_fifo_wdata,
  output logic                        o_fifo_full,
  output logic                        o_fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_count,
  input  logic                        i_flush,
  output logic                        o_flushed,
  input  logic                        i_dreq_n,
  output logic                        o_dack_n,
  output logic                        o_iow_n,
  output logic [7:0]                  o_pd_out,
  output logic                        o_pdata_oe_n
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (IOW_CYCLES > 1) ? $clog2(IOW_CYCLES) : 1;
  localparam logic [AW:0]   FULL_CNT = FIFO_DEPTH[AW:0];
  localparam logic [CW-1:0] IOW_LOAD = CW'(IOW_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RECOVER
  } state_t;

  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic [31:0]   r_hr;
  logic          r_hr_vld;
  logic [1:0]    r_byte_idx;

  state_t        r_state;
  logic [CW-1:0] r_iow_cnt;
  logic          r_dreq_seen_hi;
  logic          r_flush_pend;
  logic          r_flushed;
  logic          r_dack_n;
  logic          r_iow_n;
  logic          r_pdata_oe_n;
  logic [7:0]    r_pd_out;

  logic          w_full;
  logic          w_empty;
  logic          w_clear;
  logic          w_push;
  logic          w_pop;
  logic [7:0]    w_cur_byte;

  assign w_full     = (r_count == FULL_CNT);
  assign w_empty    = (r_count == '0);
  // Flush only takes effect between bytes; a flush seen mid-byte waits in r_flush_pend.
  assign w_clear    = ((r_state == S_IDLE) || (r_state == S_RECOVER)) && (i_flush || r_flush_pend);
  assign w_push     = i_fifo_wr && !w_full && !w_clear;
  assign w_pop      = !r_hr_vld && !w_empty && !w_clear;
  assign w_cur_byte = r_hr[{r_byte_idx, 3'b000} +: 8];

  always_ff @(posedge i_sclk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_fifo_wdata;
    end
  end

  always_ff @(posedge i_sclk) begin
    if (!i_rst_n || w_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // HOLD is the only state that retires a byte, so the index moves exactly once per strobe.
  always_ff @(posedge i_sclk) begin
    if (!i_rst_n) begin
      r_hr       <= '0;
      r_hr_vld   <= 1'b0;
      r_byte_idx <= 2'd3;
    end else if (w_clear) begin
      r_hr_vld   <= 1'b0;
      r_byte_idx <= 2'd3;
    end else if (w_pop) begin
      r_hr       <= r_mem[r_rptr];
      r_hr_vld   <= 1'b1;
      r_byte_idx <= 2'd3;
    end else if (r_state == S_HOLD) begin
      if (r_byte_idx == 2'd0) begin
        r_hr_vld <= 1'b0;
      end else begin
        r_byte_idx <= r_byte_idx - 2'd1;
      end
    end
  end

  always_ff @(posedge i_sclk) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_iow_cnt      <= '0;
      r_dreq_seen_hi <= 1'b0;
      r_flush_pend   <= 1'b0;
      r_flushed      <= 1'b0;
      r_dack_n       <= 1'b1;
      r_iow_n        <= 1'b1;
      r_pdata_oe_n   <= 1'b1;
      r_pd_out       <= 8'h00;
    end else begin
      r_flushed <= w_clear;
      if (w_clear) begin
        r_flush_pend <= 1'b0;
      end else if (i_flush) begin
        r_flush_pend <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (!w_clear && !i_dreq_n && r_hr_vld) begin
            r_state      <= S_SETUP;
            r_dack_n     <= 1'b0;
            r_pdata_oe_n <= 1'b0;
            r_pd_out     <= w_cur_byte;
          end
        end
        S_SETUP: begin
          r_state        <= S_STROBE;
          r_iow_n        <= 1'b0;
          r_iow_cnt      <= IOW_LOAD;
          r_dreq_seen_hi <= 1'b0;
        end
        S_STROBE: begin
          r_dreq_seen_hi <= r_dreq_seen_hi | i_dreq_n;
          if (r_iow_cnt == '0) begin
            r_state <= S_HOLD;
            r_iow_n <= 1'b1;
          end else begin
            r_iow_cnt <= r_iow_cnt - CW'(1);
          end
        end
        S_HOLD: begin
          r_dreq_seen_hi <= r_dreq_seen_hi | i_dreq_n;
          r_state        <= S_RECOVER;
          r_dack_n       <= 1'b1;
          r_pdata_oe_n   <= 1'b1;
        end
        S_RECOVER: begin
          // A request that never went high since the strobe is the one just served.
          if (w_clear || r_dreq_seen_hi || i_dreq_n) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_dack_n     <= 1'b1;
          r_iow_n      <= 1'b1;
          r_pdata_oe_n <= 1'b1;
        end
      endcase
    end
  end

  assign o_fifo_full  = w_full;
  assign o_fifo_empty = w_empty;
  assign o_fifo_count = r_count;
  assign o_flushed    = r_flushed;
  assign o_dack_n     = r_dack_n;
  assign o_iow_n      = r_iow_n;
  assign o_pd_out     = r_pd_out;
  assign o_pdata_oe_n = r_pdata_oe_n;

endmodule

// File: tb/tb_scsi_wr_unpack_fifo.sv
// Bench for scsi_wr_unpack_fifo: byte scoreboard checked on every _IOW strobe, plus table and corner sequences.
module tb_scsi_wr_unpack_fifo;

  localparam int IOW_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] wdata = '0;
  logic        full;
  logic        empty;
  logic [3:0]  count;
  logic        flush = 1'b0;
  logic        flushed;
  logic        dreq_n = 1'b1;
  logic        dack_n;
  logic        iow_n;
  logic [7:0]  pd;
  logic        oe_n;

  always #5 clk = ~clk;

  scsi_wr_unpack_fifo #(.FIFO_DEPTH(8), .IOW_CYCLES(IOW_CYCLES)) dut (
    .i_sclk(clk), .i_rst_n(rst_n), .i_fifo_wr(wr), .i_fifo_wdata(wdata),
    .o_fifo_full(full), .o_fifo_empty(empty), .o_fifo_count(count),
    .i_flush(flush), .o_flushed(flushed), .i_dreq_n(dreq_n),
    .o_dack_n(dack_n), .o_iow_n(iow_n), .o_pd_out(pd), .o_pdata_oe_n(oe_n)
  );

  typedef struct {
    logic        wr;
    logic [31:0] wdata;
    logic        accept;
    logic [3:0]  count;
    logic        full;
    logic        empty;
  } vec_t;

  vec_t       tv [11];
  logic [7:0] exp_q [$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         n_strobes = 0;
  int         n_flushed = 0;
  int         iow_run = 0;
  logic       prev_iow_n = 1'b1;
  logic       cut = 1'b1;
  logic       auto_dreq = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    if (!rst_n) cut = 1'b1;
    if (flushed === 1'b1) n_flushed++;
    if (iow_n === 1'b0) begin
      if (prev_iow_n) begin
        n_strobes++;
        iow_run = 0;
        cut = 1'b0;
        chk("strobe_dack_low", 32'(dack_n), 0);
        chk("strobe_oe_low", 32'(oe_n), 0);
        if (exp_q.size() == 0) chk("extra_strobe_qsize", 32'(exp_q.size()), 1);
        else chk("pd_byte", 32'(pd), 32'(exp_q.pop_front()));
      end
      iow_run++;
    end else if (!prev_iow_n && !cut) begin
      chk("iow_width", 32'(iow_run), IOW_CYCLES);
    end
    prev_iow_n = iow_n;
  endtask

  // Peripheral model: drop the request once the strobe is seen, re-raise it when _DACK goes away.
  task automatic step();
    @(posedge clk);
    #1;
    monitor();
    if (auto_dreq) begin
      if (dack_n === 1'b0 && iow_n === 1'b0) dreq_n = 1'b1;
      else if (dack_n === 1'b1) dreq_n = 1'b0;
    end
  endtask

  task automatic enqueue(input logic [31:0] w);
    exp_q.push_back(w[31:24]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  task automatic push(input logic [31:0] w);
    wr = 1'b1;
    wdata = w;
    enqueue(w);
    step();
    wr = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int i = 0;
    while ((exp_q.size() != 0 || dack_n !== 1'b1) && i < budget) begin
      step();
      i++;
    end
    chk({name, "_drain_left"}, 32'(exp_q.size()), 0);
  endtask

  initial begin
    int   base;
    int   fbase;
    logic bad;
    logic done;

    // HR absorbs the first word, so FIFO count lags the number of pushes by one after the first.
    for (int n = 0; n < 10; n++) begin
      tv[n].wr     = 1'b1;
      tv[n].wdata  = 32'h1100_0000 * 32'(n + 1);
      tv[n].accept = (n < 9);
      tv[n].count  = (n == 0) ? 4'd1 : ((n > 8) ? 4'd8 : 4'(n));
      tv[n].full   = (tv[n].count == 4'd8);
      tv[n].empty  = 1'b0;
    end
    tv[10].wr = 1'b0; tv[10].wdata = '0; tv[10].accept = 1'b0;
    tv[10].count = 4'd8; tv[10].full = 1'b1; tv[10].empty = 1'b0;

    step();
    step();
    chk("rst_dack", 32'(dack_n), 1);
    chk("rst_iow", 32'(iow_n), 1);
    chk("rst_oe", 32'(oe_n), 1);
    chk("rst_pd", 32'(pd), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_flushed", 32'(flushed), 0);
    rst_n = 1'b1;
    step();

    // Single word, peripheral handshaking, first-byte latency.
    dreq_n = 1'b0;
    auto_dreq = 1'b1;
    base = n_strobes;
    wr = 1'b1; wdata = 32'h00AB_CDEF; enqueue(wdata);
    step();
    wr = 1'b0;
    chk("t1_count_e1", 32'(count), 1);
    chk("t1_empty_e1", 32'(empty), 0);
    chk("t1_dack_e1", 32'(dack_n), 1);
    step();
    chk("t1_dack_e2", 32'(dack_n), 1);
    chk("t1_count_e2", 32'(count), 0);
    step();
    chk("t1_dack_e3", 32'(dack_n), 0);
    chk("t1_oe_e3", 32'(oe_n), 0);
    chk("t1_pd_e3", 32'(pd), 8'h00);
    drain("t1", 200);
    chk("t1_strobes", 32'(n_strobes - base), 4);
    chk("t1_empty_end", 32'(empty), 1);

    // Fill to full with the request inactive, then drain.
    auto_dreq = 1'b0;
    dreq_n = 1'b1;
    base = n_strobes;
    for (int i = 0; i < 11; i++) begin
      wr = tv[i].wr;
      wdata = tv[i].wdata;
      step();
      wr = 1'b0;
      if (tv[i].accept) enqueue(tv[i].wdata);
      chk($sformatf("t2_count_%0d", i), 32'(count), 32'(tv[i].count));
      chk($sformatf("t2_full_%0d", i), 32'(full), 32'(tv[i].full));
      chk($sformatf("t2_empty_%0d", i), 32'(empty), 32'(tv[i].empty));
    end
    auto_dreq = 1'b1;
    drain("t2", 600);
    chk("t2_strobes", 32'(n_strobes - base), 36);

    // Push coinciding with an HR reload at count 4; write pointer wraps past entry 7.
    auto_dreq = 1'b0;
    dreq_n = 1'b1;
    base = n_strobes;
    for (int n = 0; n < 8; n++) push(32'hA500_0000 + 32'(n) * 32'h0001_0203);
    chk("t4_count_loaded", 32'(count), 7);
    auto_dreq = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      step();
      if (n_strobes - base == 16 && dack_n === 1'b1) begin
        chk("t4_count_before", 32'(count), 4);
        push(32'hFEED_0008);
        chk("t4_count_pushpop", 32'(count), 4);
        done = 1'b1;
      end
    end
    chk("t4_pushpop_reached", 32'(done), 1);
    drain("t4", 600);
    chk("t4_strobes", 32'(n_strobes - base), 36);

    // Request held low: underrun first, then only one byte per high sample.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_q.delete();
    auto_dreq = 1'b0;
    dreq_n = 1'b0;
    base = n_strobes;
    bad = 1'b0;
    repeat (8) begin
      step();
      if (dack_n !== 1'b1) bad = 1'b1;
    end
    chk("t3_underrun_dack", 32'(bad), 0);
    push(32'h5A6B_7C8D);
    for (int i = 0; i < 50 && n_strobes - base < 1; i++) step();
    repeat (20) step();
    chk("t3_single_strobe", 32'(n_strobes - base), 1);
    chk("t3_dack_parked", 32'(dack_n), 1);
    dreq_n = 1'b1;
    step();
    dreq_n = 1'b0;
    for (int i = 0; i < 50 && n_strobes - base < 2; i++) step();
    chk("t3_second_strobe", 32'(n_strobes - base), 2);
    auto_dreq = 1'b1;
    drain("t3", 200);
    chk("t3_strobes", 32'(n_strobes - base), 4);

    // Double flush during the strobe of byte AB.
    base = n_strobes;
    fbase = n_flushed;
    push(32'h00AB_CDEF);
    for (int i = 0; i < 100 && n_strobes - base < 2; i++) step();
    chk("t5_reached_ab", 32'(n_strobes - base), 2);
    flush = 1'b1;
    step();
    step();
    flush = 1'b0;
    step();
    chk("t5_dack_released", 32'(dack_n), 1);
    bad = 1'b0;
    repeat (30) begin
      step();
      if (dack_n !== 1'b1) bad = 1'b1;
    end
    chk("t5_no_more_dack", 32'(bad), 0);
    chk("t5_strobes", 32'(n_strobes - base), 2);
    chk("t5_flushed_pulses", 32'(n_flushed - fbase), 1);
    chk("t5_empty", 32'(empty), 1);
    chk("t5_discarded", 32'(exp_q.size()), 2);
    exp_q.delete();

    // Reset in the middle of a strobe.
    base = n_strobes;
    push(32'h1357_9BDF);
    for (int i = 0; i < 50 && iow_n !== 1'b0; i++) step();
    chk("t6_in_strobe", 32'(iow_n), 0);
    rst_n = 1'b0;
    step();
    chk("t6_iow", 32'(iow_n), 1);
    chk("t6_dack", 32'(dack_n), 1);
    chk("t6_oe", 32'(oe_n), 1);
    chk("t6_count", 32'(count), 0);
    chk("t6_empty", 32'(empty), 1);
    rst_n = 1'b1;
    exp_q.delete();
    repeat (10) step();
    chk("t6_quiet_after", 32'(n_strobes - base), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
